// File: rtl/wb_stage_mc.sv
// Write-back stage: retires one entry per cycle into the GPR file, commits CP0 exception/ERET/mtc0,
// stalls on multi-cycle mfc0 reads. Optional trace ports are enabled by defining WB_TRACE_EN.
module wb_stage_mc #(
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int CP0_LAT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ws_allowin,
    input  logic                         ms_to_ws_valid,
    input  logic [2*DATA_W+RF_AW+80:0]   ms_to_ws_bus,
    output logic                         cp0_rd_req,
    output logic [4:0]                   cp0_raddr,
    input  logic [DATA_W-1:0]            cp0_rdata,
    output logic                         ws_to_cp0_ex,
    output logic [4:0]                   ws_to_cp0_excode,
    output logic [31:0]                  ws_to_cp0_badva,
    output logic                         ws_to_cp0_bd,
    output logic [31:0]                  ws_to_cp0_pc,
    output logic                         ws_to_cp0_we,
    output logic [4:0]                   ws_to_cp0_waddr,
    output logic [DATA_W-1:0]            ws_to_cp0_wdata,
    output logic                         ws_eret,
    output logic                         ws_flush,
    output logic                         rf_we,
    output logic [RF_AW-1:0]             rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         ws_fwd_valid,
    output logic                         ws_fwd_ready,
    output logic [RF_AW-1:0]             ws_fwd_dest,
    output logic [DATA_W-1:0]            ws_fwd_data,
`ifdef WB_TRACE_EN
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_wen,
    output logic [RF_AW-1:0]             debug_wb_rf_wnum,
    output logic [DATA_W-1:0]            debug_wb_rf_wdata,
`endif
    output logic [1:0]                   ws_dbg_state
);

    localparam int BUS_W    = 2*DATA_W + RF_AW + 81;
    localparam int PC_LSB   = 0;
    localparam int RES_LSB  = 32;
    localparam int DEST_LSB = RES_LSB + DATA_W;
    localparam int GWE_B    = DEST_LSB + RF_AW;
    localparam int EXC_LSB  = GWE_B + 1;
    localparam int EX_B     = EXC_LSB + 5;
    localparam int BVA_LSB  = EX_B + 1;
    localparam int RFC0_B   = BVA_LSB + 32;
    localparam int C0A_LSB  = RFC0_B + 1;
    localparam int MTC0_B   = C0A_LSB + 5;
    localparam int BD_B     = MTC0_B + 1;
    localparam int ERET_B   = BD_B + 1;
    localparam int RT_LSB   = ERET_B + 1;
    localparam int ADDREX_B = RT_LSB + DATA_W;
    localparam logic [2:0] LAT = 3'(CP0_LAT);

    // Handshake: MEM->WB transfer happens when ms_to_ws_valid && ws_allowin && !ws_flush.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [BUS_W-1:0]   r_bus;

    logic w_valid, w_ex, w_eret, w_mfc0, w_ready_go, w_flush, w_accept;

    assign w_valid = (r_state != S_IDLE);
    assign w_ex    = r_bus[EX_B];
    assign w_eret  = r_bus[ERET_B];
    assign w_mfc0  = r_bus[RFC0_B] && !w_ex && !w_eret;

    always_comb begin
        w_ready_go = 1'b1;
        if (r_state == S_ACTIVE && w_mfc0 && CP0_LAT != 0)
            w_ready_go = 1'b0;
        else if (r_state == S_WAIT)
            w_ready_go = (r_cnt == LAT);
    end

    // Exception/ERET can only be seen in ACTIVE: such entries never enter WAIT.
    assign w_flush    = (r_state == S_ACTIVE) && (w_ex || w_eret);
    assign ws_allowin = !w_valid || w_ready_go;
    assign w_accept   = ms_to_ws_valid && ws_allowin && !w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_bus   <= '0;
        end else begin
            if (w_accept)
                r_bus <= ms_to_ws_bus;
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (!w_ready_go) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 3'd1;
                    end else begin
                        r_state <= w_accept ? S_ACTIVE : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (w_ready_go) begin
                        r_cnt   <= 3'd0;
                        r_state <= w_accept ? S_ACTIVE : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign ws_dbg_state = r_state;

    assign cp0_rd_req = (r_state == S_ACTIVE) && w_mfc0;
    assign cp0_raddr  = r_bus[C0A_LSB +: 5];

    assign ws_flush         = w_flush;
    assign ws_to_cp0_ex     = w_flush && w_ex;
    assign ws_eret          = w_flush && !w_ex;
    assign ws_to_cp0_excode = r_bus[EXC_LSB +: 5];
    assign ws_to_cp0_badva  = r_bus[ADDREX_B] ? r_bus[PC_LSB +: 32] : r_bus[BVA_LSB +: 32];
    assign ws_to_cp0_bd     = r_bus[BD_B];
    assign ws_to_cp0_pc     = r_bus[PC_LSB +: 32];
    assign ws_to_cp0_we     = (r_state == S_ACTIVE) && r_bus[MTC0_B] && !w_ex;
    assign ws_to_cp0_waddr  = r_bus[C0A_LSB +: 5];
    assign ws_to_cp0_wdata  = r_bus[RT_LSB +: DATA_W];

    assign ws_fwd_valid = w_valid && r_bus[GWE_B] && !w_ex && !w_eret;
    assign ws_fwd_ready = w_ready_go;
    assign ws_fwd_dest  = r_bus[DEST_LSB +: RF_AW];
    assign ws_fwd_data  = rf_wdata;

    assign rf_we    = ws_fwd_valid && w_ready_go;
    assign rf_waddr = r_bus[DEST_LSB +: RF_AW];
    assign rf_wdata = r_bus[RFC0_B] ? cp0_rdata : r_bus[RES_LSB +: DATA_W];

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = r_bus[PC_LSB +: 32];
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = r_bus[DEST_LSB +: RF_AW];
    assign debug_wb_rf_wdata = rf_wdata;
`else
    // Trace ports are not present in this build.
`endif

endmodule

// File: tb/tb_wb_stage_mc.sv
// Directed, table-driven bench for wb_stage_mc built with CP0_LAT=3.
module tb_wb_stage_mc;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int BUS_W = 2*DW + AW + 81;

    logic              clk = 1'b0;
    logic              reset;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [BUS_W-1:0]  ms_to_ws_bus;
    logic              cp0_rd_req;
    logic [4:0]        cp0_raddr;
    logic [DW-1:0]     cp0_rdata;
    logic              ws_to_cp0_ex;
    logic [4:0]        ws_to_cp0_excode;
    logic [31:0]       ws_to_cp0_badva;
    logic              ws_to_cp0_bd;
    logic [31:0]       ws_to_cp0_pc;
    logic              ws_to_cp0_we;
    logic [4:0]        ws_to_cp0_waddr;
    logic [DW-1:0]     ws_to_cp0_wdata;
    logic              ws_eret;
    logic              ws_flush;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              ws_fwd_valid;
    logic              ws_fwd_ready;
    logic [AW-1:0]     ws_fwd_dest;
    logic [DW-1:0]     ws_fwd_data;
    logic [1:0]        ws_dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_mc #(.DATA_W(DW), .RF_AW(AW), .CP0_LAT(3)) dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .cp0_rd_req(cp0_rd_req), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .ws_to_cp0_ex(ws_to_cp0_ex), .ws_to_cp0_excode(ws_to_cp0_excode),
        .ws_to_cp0_badva(ws_to_cp0_badva), .ws_to_cp0_bd(ws_to_cp0_bd),
        .ws_to_cp0_pc(ws_to_cp0_pc), .ws_to_cp0_we(ws_to_cp0_we),
        .ws_to_cp0_waddr(ws_to_cp0_waddr), .ws_to_cp0_wdata(ws_to_cp0_wdata),
        .ws_eret(ws_eret), .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid), .ws_fwd_ready(ws_fwd_ready),
        .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data), .ws_dbg_state(ws_dbg_state)
    );

    typedef struct {
        logic        v;
        logic        addr_ex;
        logic [31:0] rt;
        logic        eret, bd, mtc0;
        logic [4:0]  c0a;
        logic        rfc0;
        logic [31:0] bva;
        logic        ex;
        logic [4:0]  exc;
        logic        gwe;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        ent_t        e;
        logic [31:0] cd;
        logic        a, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl, cx, er, cw, rq, fv, fr;
        logic [31:0] aux;
    } row_t;

    function automatic logic [BUS_W-1:0] pack(ent_t e);
        return {e.addr_ex, e.rt, e.eret, e.bd, e.mtc0, e.c0a, e.rfc0, e.bva,
                e.ex, e.exc, e.gwe, e.dest, e.res, e.pc};
    endfunction

    function automatic ent_t e_none();
        ent_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic ent_t e_alu(logic [4:0] dest, logic [31:0] res);
        ent_t e;
        e = e_none();
        e.v = 1'b1; e.gwe = 1'b1; e.dest = dest; e.res = res; e.pc = 32'hBFC0_0000 + {27'd0, dest};
        return e;
    endfunction

    function automatic ent_t e_mfc0(logic [4:0] dest, logic [4:0] addr);
        ent_t e;
        e = e_alu(dest, 32'h0BAD_0BAD);
        e.rfc0 = 1'b1; e.c0a = addr;
        return e;
    endfunction

    function automatic row_t mk(ent_t e, logic [31:0] cd, logic a, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic fl, logic cx, logic er, logic cw,
                                logic rq, logic fv, logic fr, logic [31:0] aux);
        row_t r;
        r.e = e; r.cd = cd; r.a = a; r.we = we; r.wa = wa; r.wd = wd; r.fl = fl; r.cx = cx;
        r.er = er; r.cw = cw; r.rq = rq; r.fv = fv; r.fr = fr; r.aux = aux;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(ent_t e, logic [31:0] cd);
        ms_to_ws_valid = e.v;
        ms_to_ws_bus   = pack(e);
        cp0_rdata      = cd;
    endtask

    task automatic apply_row(row_t r);
        drive(r.e, r.cd);
        #1;
        chk("allowin", 32'(ws_allowin), 32'(r.a));
        chk("rf_we", 32'(rf_we), 32'(r.we));
        chk("flush", 32'(ws_flush), 32'(r.fl));
        chk("cp0_ex", 32'(ws_to_cp0_ex), 32'(r.cx));
        chk("eret", 32'(ws_eret), 32'(r.er));
        chk("cp0_we", 32'(ws_to_cp0_we), 32'(r.cw));
        chk("rd_req", 32'(cp0_rd_req), 32'(r.rq));
        chk("fwd_valid", 32'(ws_fwd_valid), 32'(r.fv));
        if (r.fv) begin
            chk("fwd_ready", 32'(ws_fwd_ready), 32'(r.fr));
            chk("fwd_dest", 32'(ws_fwd_dest), 32'(r.wa));
        end
        if (r.we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(r.wa));
            chk("rf_wdata", rf_wdata, r.wd);
            chk("fwd_data", ws_fwd_data, r.wd);
        end
        if (r.cx) chk("badva", ws_to_cp0_badva, r.aux);
        if (r.cw) begin
            chk("cp0_wdata", ws_to_cp0_wdata, r.aux);
            chk("cp0_waddr", 32'(ws_to_cp0_waddr), 32'd12);
        end
        if (r.rq) chk("cp0_raddr", 32'(cp0_raddr), r.aux);
        @(posedge clk);
        #1;
    endtask

    row_t tbl[20];

    initial begin
        ent_t m, b, x, y, z, t, n;
        n = e_none();
        m = e_mfc0(5'd8, 5'd12);
        b = e_alu(5'd9, 32'h99);
        x = e_alu(5'd5, 32'h55);
        x.ex = 1'b1; x.exc = 5'h04; x.addr_ex = 1'b1; x.pc = 32'hBFC0_0100; x.bva = 32'h1234_5678;
        y = e_alu(5'd4, 32'h44);
        y.ex = 1'b1; y.eret = 1'b1; y.exc = 5'h0C; y.bva = 32'hA000_0010;
        z = e_alu(5'd7, 32'h77);
        z.eret = 1'b1;
        t = e_none();
        t.v = 1'b1; t.mtc0 = 1'b1; t.c0a = 5'd12; t.rt = 32'h0000_FF01; t.res = 32'hCAFE_0000;

        tbl[0]  = mk(e_alu(5'd1, 32'h11), 0, 1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(e_alu(5'd2, 32'h22), 0, 1, 1, 1, 32'h11,    0, 0, 0, 0, 0, 1, 1, 0);
        tbl[2]  = mk(e_alu(5'd3, 32'h33), 0, 1, 1, 2, 32'h22,    0, 0, 0, 0, 0, 1, 1, 0);
        tbl[3]  = mk(n, 0,                   1, 1, 3, 32'h33,    0, 0, 0, 0, 0, 1, 1, 0);
        tbl[4]  = mk(m, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(b, 32'h5555,            0, 0, 8, 0,         0, 0, 0, 0, 1, 1, 0, 12);
        tbl[6]  = mk(b, 32'h5555,            0, 0, 8, 0,         0, 0, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(b, 32'h5555,            0, 0, 8, 0,         0, 0, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(b, 32'hDEAD_0001,       1, 1, 8, 32'hDEAD_0001, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[9]  = mk(n, 32'hDEAD_0001,       1, 1, 9, 32'h99,    0, 0, 0, 0, 0, 1, 1, 0);
        tbl[10] = mk(x, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(e_alu(5'd6, 32'h66), 0, 1, 0, 0, 0,         1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0100);
        tbl[12] = mk(n, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(y, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(n, 0,                   1, 0, 0, 0,         1, 1, 0, 0, 0, 0, 0, 32'hA000_0010);
        tbl[15] = mk(z, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(n, 0,                   1, 0, 0, 0,         1, 0, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(t, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(n, 0,                   1, 0, 0, 0,         0, 0, 0, 1, 0, 0, 0, 32'h0000_FF01);
        tbl[19] = mk(n, 0,                   1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);

        // Clock/reset
        reset = 1'b1;
        drive(n, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_state", 32'(ws_dbg_state), 32'd0);
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_flush", 32'(ws_flush), 32'd0);
        chk("rst_fwd_valid", 32'(ws_fwd_valid), 32'd0);
        chk("rst_rd_req", 32'(cp0_rd_req), 32'd0);

        for (int i = 0; i < 20; i++) apply_row(tbl[i]);

        // Reset asserted during the second cycle of an mfc0 wait.
        drive(m, 32'h0);
        @(posedge clk);
        #1;
        drive(n, 32'h0);
        #1;
        chk("mw_rd_req", 32'(cp0_rd_req), 32'd1);
        @(posedge clk);
        #1;
        chk("mw_state_wait", 32'(ws_dbg_state), 32'd2);
        chk("mw_allowin", 32'(ws_allowin), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mw_state_idle", 32'(ws_dbg_state), 32'd0);
        chk("mw_allowin_after", 32'(ws_allowin), 32'd1);
        chk("mw_strobes", {26'd0, rf_we, cp0_rd_req, ws_to_cp0_ex, ws_to_cp0_we, ws_eret, ws_flush}, 32'd0);
        chk("mw_fwd_valid", 32'(ws_fwd_valid), 32'd0);
        cp0_rdata = 32'hDEAD_0001;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("mw_no_rf_we", 32'(rf_we), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
